// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter control front-end.
package counter_ctrl_pkg;

   localparam int RATE_SEL_W = 2;

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS_WAIT,
      DB_PRESSED,
      DB_RELEASE_WAIT
   } db_state_t;

endpackage

// File: rtl/counter_ctrl_unit_key_debounce.sv
// One push-button: 2-flop synchronizer, debounce FSM and a single-cycle press pulse.
module key_debounce
   import counter_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [1:0]       sync;
   logic             key_s;
   db_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   assign key_s = sync[1];

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         state <= DB_IDLE;
         cnt   <= '0;
      end else begin
         sync  <= {sync[0], key_n};
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The sample that leaves IDLE/PRESSED already counts as the first stable one.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_nxt = state;
      cnt_nxt   = cnt;
      press     = 1'b0;
      case (state)
         DB_IDLE: begin
            if (!key_s) begin
               state_nxt = DB_PRESS_WAIT;
               cnt_nxt   = CNT_ONE;
            end
         end
         DB_PRESS_WAIT: begin
            if (key_s) begin
               state_nxt = DB_IDLE;
               cnt_nxt   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_nxt = DB_PRESSED;
               cnt_nxt   = '0;
               press     = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         DB_PRESSED: begin
            if (key_s) begin
               state_nxt = DB_RELEASE_WAIT;
               cnt_nxt   = CNT_ONE;
            end
         end
         DB_RELEASE_WAIT: begin
            if (!key_s) begin
               state_nxt = DB_PRESSED;
               cnt_nxt   = '0;
            end else if (cnt >= CNT_LAST) begin
               state_nxt = DB_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = DB_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/counter_ctrl_unit.sv
// Counter control front-end: key debounce, rate prescaler, event priority.
// Optional step-key path compiled in with `define COUNTER_CTRL_STEP_EN.
module counter_ctrl_unit
   import counter_ctrl_pkg::*;
#(
   parameter int DB_CYCLES   = 500_000,
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iKeyClear_n,
   input  logic                  iKeyDir_n,
   input  logic                  iKeyStep_n,
   input  logic                  iRun,
   input  logic [RATE_SEL_W-1:0] iRateSel,
   output logic                  oEnable,
   output logic                  oClear,
   output logic                  oUp_down
);

   localparam int PS_W = $clog2(TICK_CYCLES);

   logic [PS_W-1:0]       ps_cnt, ps_last;
   logic [RATE_SEL_W-1:0] rate_q;
   logic                  clear_evt, dir_evt, step_fire;
   logic                  rate_chg, tick;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
      .clk(iClk), .rst_n(iReset_n), .key_n(iKeyClear_n), .press(clear_evt)
   );

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dir (
      .clk(iClk), .rst_n(iReset_n), .key_n(iKeyDir_n), .press(dir_evt)
   );

`ifdef COUNTER_CTRL_STEP_EN
   logic step_evt;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
      .clk(iClk), .rst_n(iReset_n), .key_n(iKeyStep_n), .press(step_evt)
   );

   // A step only counts while paused, and never back-to-back with a tick.
   assign step_fire = step_evt && !iRun && !oEnable;
`else
   logic step_key_unused;
   assign step_key_unused = iKeyStep_n;
   assign step_fire       = 1'b0;
`endif

   assign ps_last  = PS_W'((TICK_CYCLES >> iRateSel) - 1);
   assign rate_chg = (iRateSel != rate_q);
   assign tick     = iRun && !rate_chg && (ps_cnt == ps_last);

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         ps_cnt   <= '0;
         rate_q   <= '0;
         oEnable  <= 1'b0;
         oClear   <= 1'b0;
         oUp_down <= 1'b1;
      end else begin
         rate_q   <= iRateSel;
         oClear   <= clear_evt;
         oEnable  <= !clear_evt && (tick || step_fire);
         oUp_down <= oUp_down ^ dir_evt;
         // Clear, a rate change or a pause all restart the tick period.
         if (clear_evt || rate_chg || !iRun || tick) begin
            ps_cnt <= '0;
         end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Scoreboard bench for counter_ctrl_unit with DB_CYCLES=4, TICK_CYCLES=16.
module tb_counter_ctrl_unit;

   localparam int DB = 4;
   localparam int TK = 16;

   typedef enum logic [1:0] {EV_EN, EV_CLR, EV_DIR} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
      int       tol;
      logic     val;
   } exp_ev_t;

   logic       iClk, iReset_n, iKeyClear_n, iKeyDir_n, iKeyStep_n, iRun;
   logic [1:0] iRateSel;
   logic       oEnable, oClear, oUp_down;

   exp_ev_t exp_q[$];
   int      cyc = 0;
   int      vectors = 0;
   int      miscompares = 0;
   int      en_seen = 0;
   bit      mon_en = 0;
   logic    prev_dir = 1'b1;
   logic    prev_en = 1'b0;
   logic    prev_clr = 1'b0;

   counter_ctrl_unit #(.DB_CYCLES(DB), .TICK_CYCLES(TK)) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iKeyClear_n(iKeyClear_n),
      .iKeyDir_n(iKeyDir_n), .iKeyStep_n(iKeyStep_n), .iRun(iRun),
      .iRateSel(iRateSel), .oEnable(oEnable), .oClear(oClear), .oUp_down(oUp_down)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   always @(posedge iClk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at cycle %0d, limit reached", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_cyc(input string name, input int act, input int exp, input int tol);
      vectors++;
      if (act < exp - tol || act > exp + tol) begin
         miscompares++;
         $display("FAIL %s: seen at cycle %0d, expected cycle %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic push(input ev_kind_t k, input int c, input int tol, input logic v);
      exp_ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.tol  = tol;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic handle(input ev_kind_t k, input logic v);
      exp_ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_%s: event at cycle %0d, expected none", k.name(), cyc);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", int'(k), int'(e.kind));
         check_cyc({k.name(), "_cycle"}, cyc, e.cyc, e.tol);
         if (k == EV_DIR) check("up_down_value", int'(v), int'(e.val));
      end
   endtask

   // Monitor: every output event pops one expectation from the scoreboard.
   initial begin
      forever begin
         @(negedge iClk);
         if (mon_en) begin
            if (oEnable || oClear) check("en_clr_exclusive", int'(oEnable && oClear), 0);
            if (oClear) begin
               check("clr_consecutive", int'(prev_clr), 0);
               handle(EV_CLR, 1'b0);
            end
            if (oEnable) begin
               check("en_consecutive", int'(prev_en), 0);
               en_seen++;
               handle(EV_EN, 1'b0);
            end
            if (oUp_down !== prev_dir) begin
               handle(EV_DIR, oUp_down);
               prev_dir = oUp_down;
            end
            prev_en  = oEnable;
            prev_clr = oClear;
         end
      end
   end

   task automatic wait_to(input int t);
      while (cyc < t) begin
         @(posedge iClk);
         #1;
      end
   endtask

   initial begin
      int c, d, d2, d3, en_before, budget;
      exp_ev_t e;

      iReset_n = 1'b0; iKeyClear_n = 1'b1; iKeyDir_n = 1'b1; iKeyStep_n = 1'b1;
      iRun = 1'b0; iRateSel = 2'd0;

      // Reset state
      wait_to(2);
      check("rst_enable", int'(oEnable), 0);
      check("rst_clear", int'(oClear), 0);
      check("rst_up_down", int'(oUp_down), 1);
      wait_to(3);
      iReset_n = 1'b1;
      mon_en   = 1;

      // Free-running ticks at the base rate
      c = 5;
      wait_to(c);
      iRun = 1'b1;
      for (int i = 1; i <= 3; i++) push(EV_EN, c + TK * i, 0, 1'b0);
      wait_to(c + 48);

      // Rate changes restart the prescaler: first tick period+1 after the change
      d = cyc;
      iRateSel = 2'd1;
      for (int i = 0; i < 3; i++) push(EV_EN, d + 9 + 8 * i, 0, 1'b0);
      wait_to(d + 28);
      d2 = cyc;
      iRateSel = 2'd2;
      for (int i = 0; i < 3; i++) push(EV_EN, d2 + 5 + 4 * i, 0, 1'b0);
      wait_to(d2 + 14);
      d3 = cyc;
      iRateSel = 2'd3;
      for (int i = 0; i < 3; i++) push(EV_EN, d3 + 3 + 2 * i, 0, 1'b0);
      wait_to(d3 + 7);
      iRun = 1'b0;
      iRateSel = 2'd0;

      // Bouncing clear key: one pulse only
      c = d3 + 10;
      for (int i = 0; i < 3; i++) begin
         wait_to(c + 4 * i);
         iKeyClear_n = 1'b0;
         wait_to(c + 4 * i + 2);
         iKeyClear_n = 1'b1;
      end
      wait_to(c + 12);
      iKeyClear_n = 1'b0;
      push(EV_CLR, c + 12 + 2 + DB, 1, 1'b0);
      wait_to(c + 32); iKeyClear_n = 1'b1;
      wait_to(c + 34); iKeyClear_n = 1'b0;
      wait_to(c + 36); iKeyClear_n = 1'b1;
      wait_to(c + 50);

      // Clear coinciding with a terminal count
      c = cyc;
      iRun = 1'b1;
      push(EV_EN, c + 16, 0, 1'b0);
      push(EV_CLR, c + 32, 1, 1'b0);
      push(EV_EN, c + 48, 0, 1'b0);
      push(EV_EN, c + 64, 0, 1'b0);
      wait_to(c + 26); iKeyClear_n = 1'b0;
      wait_to(c + 40); iKeyClear_n = 1'b1;
      wait_to(c + 64); iRun = 1'b0;

      // Direction toggles, the first one on a tick cycle
      c = cyc + 2;
      wait_to(c);
      iRun = 1'b1;
      push(EV_EN, c + 16, 0, 1'b0);
      push(EV_DIR, c + 16, 0, 1'b0);
      push(EV_EN, c + 32, 0, 1'b0);
      push(EV_DIR, c + 46, 1, 1'b1);
      push(EV_EN, c + 48, 0, 1'b0);
      wait_to(c + 10); iKeyDir_n = 1'b0;
      wait_to(c + 20); iKeyDir_n = 1'b1;
      wait_to(c + 40); iKeyDir_n = 1'b0;
      wait_to(c + 48); iRun = 1'b0;
      wait_to(c + 50); iKeyDir_n = 1'b1;
      wait_to(c + 62);

      // Step key
      c = cyc;
      en_before = en_seen;
      for (int i = 0; i < 3; i++) begin
         wait_to(c + 20 * i);
         iKeyStep_n = 1'b0;
`ifdef COUNTER_CTRL_STEP_EN
         push(EV_EN, c + 20 * i + 2 + DB, 1, 1'b0);
`endif
         wait_to(c + 20 * i + 8);
         iKeyStep_n = 1'b1;
      end
      wait_to(c + 60);
`ifdef COUNTER_CTRL_STEP_EN
      check("step_pulses_paused", en_seen - en_before, 3);
`else
      check("step_ignored_no_macro", en_seen - en_before, 0);
`endif
      c = cyc;
      iRun = 1'b1;
      push(EV_EN, c + 16, 0, 1'b0);
      push(EV_EN, c + 32, 0, 1'b0);
      wait_to(c + 20); iKeyStep_n = 1'b0;
      wait_to(c + 28); iKeyStep_n = 1'b1;
      wait_to(c + 32); iRun = 1'b0;
      wait_to(c + 50);

      // Reset mid-press discards the press and restores the direction
      c = cyc;
      iKeyDir_n = 1'b0;
      push(EV_DIR, c + 2 + DB, 1, 1'b0);
      wait_to(c + 8); iKeyDir_n = 1'b1;
      wait_to(c + 20);
      iKeyClear_n = 1'b0;
      iKeyStep_n  = 1'b0;
      wait_to(c + 23);
      iReset_n = 1'b0;
      push(EV_DIR, c + 24, 0, 1'b1);
      wait_to(c + 24);
      iKeyClear_n = 1'b1;
      iKeyStep_n  = 1'b1;
      wait_to(c + 26);
      check("midpress_rst_enable", int'(oEnable), 0);
      check("midpress_rst_clear", int'(oClear), 0);
      check("midpress_rst_up_down", int'(oUp_down), 1);
      wait_to(c + 27);
      iReset_n = 1'b1;
      wait_to(c + 45);

      // Drain the scoreboard; anything left was never seen
      budget = 0;
      while (exp_q.size() > 0 && budget < 64) begin
         @(posedge iClk);
         budget++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missing_%s: expected at cycle %0d, not seen by cycle %0d", e.kind.name(), e.cyc, cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
